debug_unit: RTL and testbench

DEBUG_UNIT -- requirements
Module: debug_unit

---
 rtl/debug_unit.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_debug_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Debug unit: UART-driven instruction loader, run/step pipeline controller and state dumper.
// Build option DEBUG_UNIT_MEM_DUMP_EN appends N_MEM_DUMP data-memory words to every dump.
module debug_unit #(
    parameter int NB_DATA      = 32,
    parameter int NB_REG       = 5,
    parameter int NB_ADDR      = 7,
    parameter int N_INST_WORDS = 64,
    parameter int N_MEM_DUMP   = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_done_i,
    input  logic               tx_done_i,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    input  logic               halt_i,
    input  logic [NB_DATA-1:0] data_pc_i,
    input  logic [NB_DATA-1:0] data_reg_i,
    input  logic [NB_DATA-1:0] data_mem_i,
    output logic [NB_DATA-1:0] inst_data_o,
    output logic               inst_we_o,
    output logic [NB_DATA-1:0] inst_addr_o,
    output logic               en_pipeline_o,
    output logic               en_read_inst_o,
    output logic [NB_REG-1:0]  addr_reg_o,
    output logic               sel_reg_debug_o,
    output logic [NB_ADDR-1:0] addr_mem_o,
    output logic               sel_mem_debug_o
);

    localparam int N_REGS         = 1 << NB_REG;
    localparam int FIRST_MEM_WORD = 1 + N_REGS;
`ifdef DEBUG_UNIT_MEM_DUMP_EN
    localparam bit MEM_DUMP_EN  = 1'b1;
    localparam int N_DUMP_WORDS = FIRST_MEM_WORD + N_MEM_DUMP;
`else
    localparam bit MEM_DUMP_EN  = 1'b0;
    localparam int N_DUMP_WORDS = FIRST_MEM_WORD;
`endif
    localparam int WCNT_W = $clog2(N_DUMP_WORDS + 1);
    localparam int IDX_W  = $clog2(N_INST_WORDS);

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(N_DUMP_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_INST = IDX_W'(N_INST_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        RUN,
        STEP_WAIT,
        STEP_EXEC,
        DUMP_ADDR,
        DUMP_LATCH,
        DUMP_SEND,
        DUMP_WAIT
    } state_t;

    state_t               state_q;
    logic [1:0]           byte_cnt_q;
    logic [IDX_W-1:0]     inst_idx_q;
    logic [WCNT_W-1:0]    word_cnt_q;
    logic [NB_DATA-9:0]   load_shift_q;
    logic [NB_DATA-9:0]   dump_shift_q;
    logic                 load_end_q;
    logic                 to_idle_q;

    logic                 tx_start_q;
    logic [7:0]           tx_data_q;
    logic [NB_DATA-1:0]   inst_data_q;
    logic                 inst_we_q;
    logic [NB_DATA-1:0]   inst_addr_q;
    logic                 en_pipeline_q;
    logic                 en_read_inst_q;
    logic [NB_REG-1:0]    addr_reg_q;
    logic                 sel_reg_q;
    logic [NB_ADDR-1:0]   addr_mem_q;
    logic                 sel_mem_q;

    logic [NB_DATA-1:0]   load_word_d;
    logic [NB_DATA-1:0]   dump_word_d;
    logic                 load_halt_d;
    logic [WCNT_W-1:0]    next_word_d;

    // Word 0 is the PC, words 1..N_REGS the register file, the rest data memory.
    function automatic logic [NB_REG-1:0] reg_addr_of(input logic [WCNT_W-1:0] idx);
        logic [NB_REG-1:0] addr;
        addr = '0;
        if (idx != '0 && idx < WCNT_W'(FIRST_MEM_WORD))
            addr = NB_REG'(32'(idx) - 32'd1);
        return addr;
    endfunction

    function automatic logic [NB_ADDR-1:0] mem_addr_of(input logic [WCNT_W-1:0] idx);
        logic [NB_ADDR-1:0] addr;
        addr = '0;
        if (idx >= WCNT_W'(FIRST_MEM_WORD))
            addr = NB_ADDR'(32'(idx) - 32'(FIRST_MEM_WORD));
        return addr;
    endfunction

    assign load_word_d = {load_shift_q, rx_data_i};
    assign load_halt_d = (load_word_d[NB_DATA-1 -: 6] == 6'b111111);
    assign next_word_d = word_cnt_q + WCNT_W'(1);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        dump_word_d = data_mem_i;
        if (word_cnt_q == '0)
            dump_word_d = data_pc_i;
        else if (word_cnt_q < WCNT_W'(FIRST_MEM_WORD))
            dump_word_d = data_reg_i;
    end

    // NOTE: state is updated with non-blocking assignments only; the pulse defaults at the top
    // are overridden by later assignments in the same cycle.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            byte_cnt_q     <= '0;
            inst_idx_q     <= '0;
            word_cnt_q     <= '0;
            load_shift_q   <= '0;
            dump_shift_q   <= '0;
            load_end_q     <= 1'b0;
            to_idle_q      <= 1'b0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
            inst_data_q    <= '0;
            inst_we_q      <= 1'b0;
            inst_addr_q    <= '0;
            en_pipeline_q  <= 1'b0;
            en_read_inst_q <= 1'b1;
            addr_reg_q     <= '0;
            sel_reg_q      <= 1'b0;
            addr_mem_q     <= '0;
            sel_mem_q      <= 1'b0;
        end else begin
            inst_we_q  <= 1'b0;
            tx_start_q <= 1'b0;

            // A halt seen from the step pulse onward ends stepping after this dump.
            if (halt_i && (state_q inside {STEP_EXEC, DUMP_ADDR, DUMP_LATCH, DUMP_SEND, DUMP_WAIT}))
                to_idle_q <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (rx_done_i) begin
                        case (rx_data_i)
                            CMD_LOAD: begin
                                state_q        <= LOAD;
                                en_read_inst_q <= 1'b0;
                                byte_cnt_q     <= '0;
                                inst_idx_q     <= '0;
                                load_end_q     <= 1'b0;
                            end
                            CMD_RUN: begin
                                state_q       <= RUN;
                                en_pipeline_q <= 1'b1;
                            end
                            CMD_STEP: begin
                                state_q   <= STEP_WAIT;
                                to_idle_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end

                LOAD: begin
                    if (load_end_q) begin
                        state_q        <= IDLE;
                        en_read_inst_q <= 1'b1;
                        load_end_q     <= 1'b0;
                    end else if (rx_done_i) begin
                        load_shift_q <= load_word_d[NB_DATA-9:0];
                        byte_cnt_q   <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            inst_data_q <= load_word_d;
                            inst_addr_q <= NB_DATA'({inst_idx_q, 2'b00});
                            inst_we_q   <= 1'b1;
                            inst_idx_q  <= inst_idx_q + IDX_W'(1);
                            if (load_halt_d || inst_idx_q == LAST_INST)
                                load_end_q <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (halt_i) begin
                        en_pipeline_q <= 1'b0;
                        to_idle_q     <= 1'b1;
                        state_q       <= DUMP_ADDR;
                        word_cnt_q    <= '0;
                        byte_cnt_q    <= '0;
                        sel_reg_q     <= 1'b1;
                        sel_mem_q     <= MEM_DUMP_EN;
                        addr_reg_q    <= '0;
                        addr_mem_q    <= '0;
                    end
                end

                STEP_WAIT: begin
                    if (rx_done_i && rx_data_i == CMD_NEXT) begin
                        state_q       <= STEP_EXEC;
                        en_pipeline_q <= 1'b1;
                    end
                end

                STEP_EXEC: begin
                    en_pipeline_q <= 1'b0;
                    state_q       <= DUMP_ADDR;
                    word_cnt_q    <= '0;
                    byte_cnt_q    <= '0;
                    sel_reg_q     <= 1'b1;
                    sel_mem_q     <= MEM_DUMP_EN;
                    addr_reg_q    <= '0;
                    addr_mem_q    <= '0;
                end

                DUMP_ADDR: state_q <= DUMP_LATCH;

                DUMP_LATCH: begin
                    tx_data_q    <= dump_word_d[NB_DATA-1 -: 8];
                    dump_shift_q <= dump_word_d[NB_DATA-9:0];
                    tx_start_q   <= 1'b1;
                    byte_cnt_q   <= '0;
                    state_q      <= DUMP_SEND;
                end

                DUMP_SEND: state_q <= DUMP_WAIT;

                DUMP_WAIT: begin
                    if (tx_done_i) begin
                        if (byte_cnt_q != 2'd3) begin
                            byte_cnt_q   <= byte_cnt_q + 2'd1;
                            tx_data_q    <= dump_shift_q[NB_DATA-9 -: 8];
                            dump_shift_q <= {dump_shift_q[NB_DATA-17:0], 8'h00};
                            tx_start_q   <= 1'b1;
                            state_q      <= DUMP_SEND;
                        end else if (word_cnt_q == LAST_WORD) begin
                            state_q    <= (to_idle_q || halt_i) ? IDLE : STEP_WAIT;
                            word_cnt_q <= '0;
                            byte_cnt_q <= '0;
                            sel_reg_q  <= 1'b0;
                            sel_mem_q  <= 1'b0;
                            addr_reg_q <= '0;
                            addr_mem_q <= '0;
                        end else begin
                            word_cnt_q <= next_word_d;
                            byte_cnt_q <= '0;
                            addr_reg_q <= reg_addr_of(next_word_d);
                            addr_mem_q <= mem_addr_of(next_word_d);
                            state_q    <= DUMP_ADDR;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_start_o      = tx_start_q;
    assign tx_data_o       = tx_data_q;
    assign inst_data_o     = inst_data_q;
    assign inst_we_o       = inst_we_q;
    assign inst_addr_o     = inst_addr_q;
    // The pipeline must stop in the very cycle halt is observed, so RUN gates the enable with halt_i.
    assign en_pipeline_o   = en_pipeline_q && !(state_q == RUN && halt_i);
    assign en_read_inst_o  = en_read_inst_q;
    assign addr_reg_o      = addr_reg_q;
    assign sel_reg_debug_o = sel_reg_q;
    assign addr_mem_o      = addr_mem_q;
    assign sel_mem_debug_o = sel_mem_q;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: vector table for reset/load/step entry, directed
// sequences for dumps, run-to-halt, full program load and reset recovery.
module tb_debug_unit;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_ADDR = 7;
`ifdef DEBUG_UNIT_MEM_DUMP_EN
    localparam int   N_DUMP_WORDS = 65;
    localparam logic EXP_SEL_MEM  = 1'b1;
`else
    localparam int   N_DUMP_WORDS = 33;
    localparam logic EXP_SEL_MEM  = 1'b0;
`endif
    localparam int N_DUMP_BYTES = 4 * N_DUMP_WORDS;

    logic               clock_i = 1'b0;
    logic               reset_i = 1'b1;
    logic [7:0]         rx_data_i = '0;
    logic               rx_done_i = 1'b0;
    logic               tx_done_i = 1'b0;
    logic               tx_start_o;
    logic [7:0]         tx_data_o;
    logic               halt_i = 1'b0;
    logic [NB_DATA-1:0] data_pc_i;
    logic [NB_DATA-1:0] data_reg_i = '0;
    logic [NB_DATA-1:0] data_mem_i = '0;
    logic [NB_DATA-1:0] inst_data_o;
    logic               inst_we_o;
    logic [NB_DATA-1:0] inst_addr_o;
    logic               en_pipeline_o;
    logic               en_read_inst_o;
    logic [NB_REG-1:0]  addr_reg_o;
    logic               sel_reg_debug_o;
    logic [NB_ADDR-1:0] addr_mem_o;
    logic               sel_mem_debug_o;

    debug_unit dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .rx_data_i      (rx_data_i),
        .rx_done_i      (rx_done_i),
        .tx_done_i      (tx_done_i),
        .tx_start_o     (tx_start_o),
        .tx_data_o      (tx_data_o),
        .halt_i         (halt_i),
        .data_pc_i      (data_pc_i),
        .data_reg_i     (data_reg_i),
        .data_mem_i     (data_mem_i),
        .inst_data_o    (inst_data_o),
        .inst_we_o      (inst_we_o),
        .inst_addr_o    (inst_addr_o),
        .en_pipeline_o  (en_pipeline_o),
        .en_read_inst_o (en_read_inst_o),
        .addr_reg_o     (addr_reg_o),
        .sel_reg_debug_o(sel_reg_debug_o),
        .addr_mem_o     (addr_mem_o),
        .sel_mem_debug_o(sel_mem_debug_o)
    );

    always #5 clock_i = ~clock_i;

    int errors = 0;
    int checks = 0;
    logic [31:0] pc_val = 32'h8000_0100;

    function automatic logic [31:0] reg_val(input logic [4:0] r);
        return {8'h10 + {3'b000, r}, 8'h20, 8'h30, {3'b000, r}};
    endfunction

    function automatic logic [31:0] mem_val(input logic [6:0] m);
        return {8'hD0, {1'b0, m}, 8'h5A, ~{1'b0, m}};
    endfunction

    function automatic logic [31:0] word_val(input int w);
        if (w == 0) return pc_val;
        if (w <= 32) return reg_val(5'(w - 1));
        return mem_val(7'(w - 33));
    endfunction

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = word_val(i / 4);
        return w[8 * (3 - (i % 4)) +: 8];
    endfunction

    // Environment: PC is combinational, register file and data memory have one cycle read latency.
    assign data_pc_i = pc_val;
    always @(posedge clock_i) begin
        data_reg_i <= reg_val(addr_reg_o);
        data_mem_i <= mem_val(addr_mem_o);
    end

    logic [31:0] we_addr_q[$];
    logic [31:0] we_data_q[$];
    logic [7:0]  tx_q[$];
    int   en_cycles = 0;
    int   tx_pending = 0;
    int   pulse_err = 0;
    int   stab_err = 0;
    int   sel_err = 0;
    logic [7:0] last_tx = '0;
    logic prev_tx_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: inputs sampled at the edge, outputs observed 1 ns later; a UART model
    // answers each tx_start with a tx_done pulse three cycles later.
    task automatic step();
        @(posedge clock_i);
        #1;
        rx_done_i = 1'b0;
        tx_done_i = 1'b0;
        if (reset_i) begin
            tx_pending = 0;
        end else if (tx_pending > 0) begin
            tx_pending--;
            if (tx_pending == 0) begin
                tx_done_i = 1'b1;
                if (tx_data_o !== last_tx) stab_err++;
            end
        end
        if (inst_we_o === 1'b1) begin
            we_addr_q.push_back(inst_addr_o);
            we_data_q.push_back(inst_data_o);
        end
        if (tx_start_o === 1'b1) begin
            if (prev_tx_start) pulse_err++;
            tx_q.push_back(tx_data_o);
            last_tx = tx_data_o;
            tx_pending = 3;
            if (sel_reg_debug_o !== 1'b1 || sel_mem_debug_o !== EXP_SEL_MEM) sel_err++;
        end
        prev_tx_start = tx_start_o;
        if (en_pipeline_o === 1'b1) en_cycles++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i = b;
        rx_done_i = 1'b1;
        step();
        step();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8 * i +: 8]);
    endtask

    task automatic wait_dump(input string name);
        int guard;
        int fi;
        logic [31:0] pcw;
        guard = 0;
        while (tx_q.size() < N_DUMP_BYTES && guard < 4000) begin
            step();
            guard++;
        end
        repeat (6) step();
        check({name, " byte count"}, tx_q.size(), N_DUMP_BYTES);
        pcw = '0;
        for (int i = 0; i < 4; i++) pcw = {pcw[23:0], (i < tx_q.size()) ? tx_q[i] : 8'h00};
        check({name, " PC word"}, pcw, pc_val);
        fi = 0;
        for (int i = tx_q.size() - 1; i >= 0; i--)
            if (i < N_DUMP_BYTES && tx_q[i] !== exp_byte(i)) fi = i;
        check($sformatf("%s byte %0d", name, fi), (fi < tx_q.size()) ? 32'(tx_q[fi]) : 32'hFFFF_FFFF,
              32'(exp_byte(fi)));
        check({name, " sel after"}, {sel_reg_debug_o, sel_mem_debug_o}, 2'b00);
        tx_q.delete();
    endtask

    typedef struct {
        logic        rst;
        logic        rx_done;
        logic [7:0]  rx_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd;
        logic        en;
        logic        sel;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // rst rx_done rx_data | we addr data rd en sel   (outputs after the edge)
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h99, 1'b0, 32'h0, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h4C, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h20, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h01, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h05, 1'b1, 32'h0, 32'h20010005,  1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h20010005,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'hFC, 1'b0, 32'h0, 32'h20010005,  1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 32'h0, 32'h20010005,  1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 32'h0, 32'h20010005,  1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 32'h4, 32'hFC000000,  1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h4, 32'hFC000000,  1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 8'h53, 1'b0, 32'h4, 32'hFC000000,  1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 8'h41, 1'b0, 32'h4, 32'hFC000000,  1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 8'h4E, 1'b0, 32'h4, 32'hFC000000,  1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h4, 32'hFC000000,  1'b1, 1'b0, 1'b1};

        step();
        en_cycles = 0;
        for (int i = 0; i < 18; i++) begin
            reset_i   = vecs[i].rst;
            rx_done_i = vecs[i].rx_done;
            rx_data_i = vecs[i].rx_data;
            step();
            check($sformatf("vec%0d inst_we", i),   inst_we_o,       vecs[i].we);
            check($sformatf("vec%0d inst_addr", i), inst_addr_o,     vecs[i].addr);
            check($sformatf("vec%0d inst_data", i), inst_data_o,     vecs[i].data);
            check($sformatf("vec%0d en_read", i),   en_read_inst_o,  vecs[i].rd);
            check($sformatf("vec%0d en_pipe", i),   en_pipeline_o,   vecs[i].en);
            check($sformatf("vec%0d sel_reg", i),   sel_reg_debug_o, vecs[i].sel);
            if (i == 0) begin
                check("reset tx_start", tx_start_o, 0);
                check("reset tx_data", tx_data_o, 0);
                check("reset addr_reg/mem", {addr_reg_o, addr_mem_o}, 0);
                check("reset sel_mem", sel_mem_debug_o, 0);
            end
        end
        check("load write count", we_addr_q.size(), 2);

        // Three single steps, each followed by a full dump and a return to STEP_WAIT.
        wait_dump("step1");
        check("step1 en pulses", en_cycles, 1);
        for (int k = 2; k <= 3; k++) begin
            pc_val = 32'h8000_0100 + 32'(k * 4);
            en_cycles = 0;
            send_byte(8'h4E);
            wait_dump($sformatf("step%0d", k));
            check($sformatf("step%0d en pulses", k), en_cycles, 1);
        end

        // Step with halt asserted: one pulse, one dump, then IDLE ignores N and 0x99.
        pc_val = 32'h9ABC_DEF0;
        halt_i = 1'b1;
        en_cycles = 0;
        send_byte(8'h4E);
        wait_dump("halt step");
        halt_i = 1'b0;
        check("halt step en pulses", en_cycles, 1);
        en_cycles = 0;
        send_byte(8'h4E);
        send_byte(8'h99);
        repeat (10) step();
        check("idle after halt step en", en_cycles, 0);
        check("idle after halt step tx", tx_q.size(), 0);
        check("idle after halt step en_read", en_read_inst_o, 1);

        // Run until halt at cycle 50.
        pc_val = 32'h8765_4321;
        begin
            int bad;
            bad = 0;
            rx_data_i = 8'h43;
            rx_done_i = 1'b1;
            step();
            for (int c = 1; c <= 49; c++) begin
                if (en_pipeline_o !== 1'b1) bad++;
                step();
            end
            check("run en low cycles in 1..49", bad, 0);
            halt_i = 1'b1;
            #1;
            check("run en drops with halt", en_pipeline_o, 0);
            step();
            halt_i = 1'b0;
            check("run dump sel_reg", sel_reg_debug_o, 1);
            check("run en after halt", en_pipeline_o, 0);
        end
        wait_dump("run");
        en_cycles = 0;
        send_byte(8'h4E);
        repeat (5) step();
        check("idle after run en", en_cycles, 0);
        check("tx_start pulse width", pulse_err, 0);
        check("tx_data stable until tx_done", stab_err, 0);
        check("sel during dump", sel_err, 0);

        // Full 64-word program with no HALT; a 65th word falls into IDLE.
        we_addr_q.delete();
        we_data_q.delete();
        send_byte(8'h4C);
        for (int k = 0; k < 64; k++) begin
            send_word({8'h04, 8'h00, 8'(k), 8'(k)});
            if (k == 10) check("en_read low in load", en_read_inst_o, 0);
        end
        repeat (2) step();
        check("64 word write count", we_addr_q.size(), 64);
        check("64 word last addr", (we_addr_q.size() > 0) ? we_addr_q[$] : 32'hFFFF_FFFF, 252);
        begin
            int fi;
            fi = 0;
            for (int k = we_addr_q.size() - 1; k >= 0; k--)
                if (we_addr_q[k] !== 32'(4 * k) || we_data_q[k] !== {8'h04, 8'h00, 8'(k), 8'(k)}) fi = k;
            check($sformatf("load word %0d addr", fi), (fi < we_addr_q.size()) ? we_addr_q[fi] : 32'hFFFF_FFFF,
                  32'(4 * fi));
            check($sformatf("load word %0d data", fi), (fi < we_data_q.size()) ? we_data_q[fi] : 32'hFFFF_FFFF,
                  {8'h04, 8'h00, 8'(fi), 8'(fi)});
        end
        check("en_read after full load", en_read_inst_o, 1);
        send_word(32'h0400_0041);
        repeat (4) step();
        check("65th word ignored", we_addr_q.size(), 64);

        // Reset after two bytes of a word discards them; the next load restarts at 0.
        we_addr_q.delete();
        we_data_q.delete();
        send_byte(8'h4C);
        send_byte(8'h12);
        send_byte(8'h34);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("mid-load reset inst_data", inst_data_o, 0);
        check("mid-load reset en_read", en_read_inst_o, 1);
        step();
        send_byte(8'h4C);
        send_word(32'hABCD_EF01);
        send_word(32'hFC00_0000);
        repeat (2) step();
        check("reload write count", we_addr_q.size(), 2);
        check("reload first addr", (we_addr_q.size() > 0) ? we_addr_q[0] : 32'hFFFF_FFFF, 0);
        check("reload first data", (we_data_q.size() > 0) ? we_data_q[0] : 32'hFFFF_FFFF, 32'hABCD_EF01);

        // Reset in the middle of a dump stops all further transmission.
        send_byte(8'h53);
        send_byte(8'h4E);
        begin
            int guard;
            guard = 0;
            while (tx_q.size() < 5 && guard < 200) begin
                step();
                guard++;
            end
        end
        check("mid-dump bytes before reset", tx_q.size(), 5);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        tx_q.delete();
        repeat (40) step();
        check("no tx after mid-dump reset", tx_q.size(), 0);
        check("sel after mid-dump reset", {sel_reg_debug_o, sel_mem_debug_o}, 2'b00);
        check("tx_data after mid-dump reset", tx_data_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
